rtc_bus_arbiter: RTL

Shares the single RTC parallel-bus access unit between two masters. Master 0 is the periodic register-read sequencer (command, clock, date and timer registers). Master 1 is the user time/date/timer write sequencer. A built-in refresh timer schedules master-0 read sweeps; the block grants the bus to one master at a time, muxes that master's bus controls, and inserts an idle gap between owners.

---
 rtl/rtc_pkg.sv | 46 ++++
 rtl/rtc_refresh_timer.sv | 23 ++
 rtl/rtc_bus_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC bus definitions: arbiter state encoding, owner ids, bus payload
// and register addresses used by the read and write sequencers.
package rtc_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ACT  = 2'd1,
    ST_WR_ACT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } arb_state_e;

  localparam logic OWNER_RD = 1'b0;
  localparam logic OWNER_WR = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
    logic              rd;
  } bus_req_t;

  // RTC register map shared by both sequencers
  localparam logic [ADDR_W-1:0] RTC_REG_CMD   = 8'h00;
  localparam logic [ADDR_W-1:0] RTC_REG_SEC   = 8'h01;
  localparam logic [ADDR_W-1:0] RTC_REG_MIN   = 8'h02;
  localparam logic [ADDR_W-1:0] RTC_REG_HOUR  = 8'h03;
  localparam logic [ADDR_W-1:0] RTC_REG_DAY   = 8'h04;
  localparam logic [ADDR_W-1:0] RTC_REG_MON   = 8'h05;
  localparam logic [ADDR_W-1:0] RTC_REG_YEAR  = 8'h06;
  localparam logic [ADDR_W-1:0] RTC_REG_TIMER = 8'h07;

  function automatic bus_req_t pack_bus(input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data,
                                        input logic wr, input logic rd);
    bus_req_t b;
    b.addr = addr;
    b.data = data;
    b.wr   = wr;
    b.rd   = rd;
    return b;
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh counter; tick_c is high on the wrap cycle
// (count == CYCLES-1), once every CYCLES clocks.
module rtc_refresh_timer #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == CNT_W'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (tick_c) cnt_q <= '0;
    else             cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter sharing the RTC bus access unit between the periodic
// read sequencer (m0) and the user write sequencer (m1), with a forced idle
// gap between owners. Define RTC_ARB_TIMEOUT_EN to add the per-grant watchdog.
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES   = 1000000,
  parameter int unsigned HOLDOFF_CYCLES   = 4,
  parameter int unsigned MAX_GRANT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  output logic       m0_gnt,
  input  logic       m0_done,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_data,
  input  logic       m0_wr,
  input  logic       m0_rd,
  output logic       m0_fin,
  input  logic       m1_req,
  output logic       m1_gnt,
  input  logic       m1_done,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_data,
  input  logic       m1_wr,
  input  logic       m1_rd,
  output logic       m1_fin,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_data,
  output logic       bus_wr,
  output logic       bus_rd,
  input  logic       bus_fin,
  output logic       busy,
  output logic       err_timeout
);

  localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  if (REFRESH_CYCLES < 2) begin : g_bad_refresh
    $error("REFRESH_CYCLES must be at least 2");
  end
  if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
    $error("HOLDOFF_CYCLES must be at least 1");
  end
  if (MAX_GRANT_CYCLES < 1) begin : g_bad_max_grant
    $error("MAX_GRANT_CYCLES must be at least 1");
  end

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              last_owner_q;
  logic              rd_pending_q;
  logic              refresh_tick;
  logic              rd_req;
  logic              hold_done;
  logic              timeout_hit;
  logic              m0_gnt_d, m1_gnt_d, busy_d;
  bus_req_t          bus_sel;

  rtc_refresh_timer #(
    .CYCLES (REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk    (clk),
    .reset  (reset),
    .tick_c (refresh_tick)
  );

  // A tick on the same cycle as the IDLE decision is served directly
  assign rd_req    = rd_pending_q | refresh_tick;
  assign hold_done = (hold_cnt_q == HOLD_W'(HOLDOFF_CYCLES - 1));

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      last_owner_q <= OWNER_WR;
      rd_pending_q <= 1'b0;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      m0_gnt       <= m0_gnt_d;
      m1_gnt       <= m1_gnt_d;
      busy         <= busy_d;
      hold_cnt_q   <= (state_q == ST_HOLDOFF && !hold_done) ? hold_cnt_q + HOLD_W'(1) : '0;
      rd_pending_q <= rd_req & ~(state_q == ST_IDLE && state_d == ST_RD_ACT);
      if (state_q == ST_IDLE && state_d == ST_RD_ACT) last_owner_q <= OWNER_RD;
      if (state_q == ST_IDLE && state_d == ST_WR_ACT) last_owner_q <= OWNER_WR;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req && m1_req)
          state_d = (last_owner_q == OWNER_WR) ? ST_RD_ACT : ST_WR_ACT;
        else if (rd_req)
          state_d = ST_RD_ACT;
        else if (m1_req)
          state_d = ST_WR_ACT;
      end
      ST_RD_ACT: begin
        if (m0_done || timeout_hit) state_d = ST_HOLDOFF;
      end
      ST_WR_ACT: begin
        if (m1_done || !m1_req || timeout_hit) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_done) state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode of the next state, registered above
  always_comb begin
    m0_gnt_d = 1'b0;
    m1_gnt_d = 1'b0;
    busy_d   = 1'b0;
    case (state_d)
      ST_RD_ACT:  begin m0_gnt_d = 1'b1; busy_d = 1'b1; end
      ST_WR_ACT:  begin m1_gnt_d = 1'b1; busy_d = 1'b1; end
      ST_HOLDOFF: busy_d = 1'b1;
      default:    ;
    endcase
  end

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(MAX_GRANT_CYCLES + 1);

  logic [AGE_W-1:0] age_q;
  logic             err_q;
  logic             granted;
  logic             grant_ending;

  assign granted      = (state_q == ST_RD_ACT) || (state_q == ST_WR_ACT);
  assign grant_ending = (state_q == ST_RD_ACT && m0_done) ||
                        (state_q == ST_WR_ACT && (m1_done || !m1_req));
  assign timeout_hit  = granted && !grant_ending && (age_q == AGE_W'(MAX_GRANT_CYCLES - 1));
  assign err_timeout  = err_q;

  // Grant age restarts on every grant entry; error is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '0;
      err_q <= 1'b0;
    end else begin
      age_q <= (granted && state_d == state_q) ? age_q + AGE_W'(1) : '0;
      err_q <= err_q | timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Bus mux follows the registered grants
  always_comb begin
    bus_sel = '0;
    if (m0_gnt)      bus_sel = pack_bus(m0_addr, m0_data, m0_wr, m0_rd);
    else if (m1_gnt) bus_sel = pack_bus(m1_addr, m1_data, m1_wr, m1_rd);
  end

  assign bus_addr = bus_sel.addr;
  assign bus_data = bus_sel.data;
  assign bus_wr   = bus_sel.wr;
  assign bus_rd   = bus_sel.rd;
  assign m0_fin   = m0_gnt & bus_fin;
  assign m1_fin   = m1_gnt & bus_fin;

endmodule
